// File: rtl/proc_pkg.sv
// Shared encodings for the instruction sequencer: opcodes, ALU operations,
// the T-step state type and a constant clog2 helper.
package proc_pkg;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_MVNZ = 3'b101;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;

  typedef enum logic [1:0] {T0, T1, T2, T3} state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) res = unsigned'(i + 1);
    end
    return res;
  endfunction

endpackage

// File: rtl/step_counter.sv
// Two-bit T-step counter; clear wins over advance so a done cycle always
// returns the sequence to T0.
module step_counter (
  input  logic       clock,
  input  logic       resetn,
  input  logic       clear,
  input  logic       advance,
  output logic [1:0] step
);

  logic [1:0] step_q, step_d;

  always_comb begin
    step_d = step_q;
    if (clear) begin
      step_d = 2'd0;
    end else if (advance) begin
      step_d = step_q + 2'd1;
    end
  end

  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      step_q <= 2'd0;
    end else begin
      step_q <= step_d;
    end
  end

  assign step = step_q;

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control unit: latches an instruction on run and steps T1..T3,
// driving bus-mux, register and ALU enables from the T-step and latched IR.
module control_sequencer
  import proc_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NUM_REGS = 8,
  localparam int unsigned RX_W    = clog2(NUM_REGS),
  localparam int unsigned MUX_W   = clog2(NUM_REGS + 2)
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                run,
  input  logic [DATA_W-1:0]   iin,
  input  logic                g_zero,
  output logic                ir_enable,
  output logic [MUX_W-1:0]    mux_key,
  output logic [NUM_REGS-1:0] regs_enable,
  output logic                a_enable,
  output logic                g_enable,
  output logic [1:0]          alu_op_selec,
  output logic                done,
  output logic                busy,
  output logic                illegal
);

  if (3 + 2 * RX_W > DATA_W) begin : g_bad_width
    $fatal(1, "control_sequencer: DATA_W too narrow for opcode and register fields");
  end

  logic [DATA_W-1:0]   ir_q;
  logic [1:0]          step;
  state_e              state;
  logic [2:0]          opcode;
  logic [RX_W-1:0]     rx, ry;
  logic [NUM_REGS-1:0] rx_onehot;
  logic [1:0]          alu_op;

  assign opcode    = ir_q[DATA_W-1 -: 3];
  assign rx        = ir_q[DATA_W-4 -: RX_W];
  assign ry        = ir_q[DATA_W-4-RX_W -: RX_W];
  assign rx_onehot = NUM_REGS'(1) << rx;

  if (DATA_W > 3 + 2 * RX_W) begin : g_unused
    logic unused_ir;
    assign unused_ir = ^ir_q[DATA_W-4-2*RX_W:0];
  end

  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      ir_q <= '0;
    end else if (ir_enable) begin
      ir_q <= iin;
    end
  end

  step_counter u_step_counter (
    .clock   (clock),
    .resetn  (resetn),
    .clear   (done),
    .advance (busy | ir_enable),
    .step    (step)
  );

  assign state = state_e'(step);
  assign busy  = (state != T0);

  always_comb begin
    unique case (opcode)
      OP_SUB:  alu_op = ALU_SUB;
      OP_AND:  alu_op = ALU_AND;
      default: alu_op = ALU_ADD;
    endcase
  end

  always_comb begin
    ir_enable    = 1'b0;
    mux_key      = '0;
    regs_enable  = '0;
    a_enable     = 1'b0;
    g_enable     = 1'b0;
    alu_op_selec = ALU_ADD;
    done         = 1'b0;
    illegal      = 1'b0;
    unique case (state)
      // Gated by reset so every output reads 0 while reset is held.
      T0: ir_enable = run & ~resetn;
      T1: begin
        unique case (opcode)
          OP_MV: begin
            mux_key     = MUX_W'(ry);
            regs_enable = rx_onehot;
            done        = 1'b1;
          end
          OP_MVI: begin
            mux_key     = MUX_W'(NUM_REGS + 1);
            regs_enable = rx_onehot;
            done        = 1'b1;
          end
          OP_MVNZ: begin
            if (!g_zero) begin
              mux_key     = MUX_W'(ry);
              regs_enable = rx_onehot;
            end
            done = 1'b1;
          end
          OP_ADD, OP_SUB, OP_AND: begin
            mux_key  = MUX_W'(rx);
            a_enable = 1'b1;
          end
          default: begin
            done    = 1'b1;
            illegal = 1'b1;
          end
        endcase
      end
      T2: begin
        mux_key      = MUX_W'(ry);
        g_enable     = 1'b1;
        alu_op_selec = alu_op;
      end
      T3: begin
        mux_key     = MUX_W'(NUM_REGS);
        regs_enable = rx_onehot;
        done        = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer (DATA_W=16, NUM_REGS=8) with
// hand-computed expected output vectors per T-step.
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        resetn;
  logic        run;
  logic [15:0] iin;
  logic        g_zero;
  logic        ir_enable;
  logic [3:0]  mux_key;
  logic [7:0]  regs_enable;
  logic        a_enable;
  logic        g_enable;
  logic [1:0]  alu_op_selec;
  logic        done;
  logic        busy;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  control_sequencer #(
    .DATA_W   (16),
    .NUM_REGS (8)
  ) dut (
    .clock        (clock),
    .resetn       (resetn),
    .run          (run),
    .iin          (iin),
    .g_zero       (g_zero),
    .ir_enable    (ir_enable),
    .mux_key      (mux_key),
    .regs_enable  (regs_enable),
    .a_enable     (a_enable),
    .g_enable     (g_enable),
    .alu_op_selec (alu_op_selec),
    .done         (done),
    .busy         (busy),
    .illegal      (illegal)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Field order: ir_enable, mux_key, regs_enable, a_en, g_en, alu, done, busy, illegal
  task automatic check_out(input string tag, input logic ire, input logic [3:0] mux,
                           input logic [7:0] regs, input logic ae, input logic ge,
                           input logic [1:0] alu, input logic dn, input logic bs,
                           input logic il);
    logic [19:0] obs, exp;
    #1;
    obs = {ir_enable, mux_key, regs_enable, a_enable, g_enable, alu_op_selec, done, busy,
           illegal};
    exp = {ire, mux, regs, ae, ge, alu, dn, bs, il};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check_out(tag, 0, 4'd0, 8'h00, 0, 0, 2'b00, 0, 0, 0);
  endtask

  initial begin
    resetn = 1'b1;
    run    = 1'b1;
    iin    = 16'h2C00;
    g_zero = 1'b0;
    #2;
    tick();
    check_idle("reset_run_high");
    tick();
    check_idle("reset_held");

    resetn = 1'b0;
    run    = 1'b0;
    check_idle("idle");
    tick();
    check_idle("idle_stay");

    // mvi R3, immediate follows
    run = 1'b1; iin = 16'h2C00;
    check_out("mvi_t0", 1, 4'd0, 8'h00, 0, 0, 2'b00, 0, 0, 0);
    tick();
    run = 1'b0; iin = 16'h00AB;
    check_out("mvi_t1", 0, 4'd9, 8'h08, 0, 0, 2'b00, 1, 1, 0);
    tick();
    check_idle("mvi_done");

    // add R1,R2
    run = 1'b1; iin = 16'h4500;
    check_out("add_t0", 1, 4'd0, 8'h00, 0, 0, 2'b00, 0, 0, 0);
    tick();
    run = 1'b0;
    check_out("add_t1", 0, 4'd1, 8'h00, 1, 0, 2'b00, 0, 1, 0);
    tick();
    check_out("add_t2", 0, 4'd2, 8'h00, 0, 1, 2'b00, 0, 1, 0);
    tick();
    check_out("add_t3", 0, 4'd8, 8'h02, 0, 0, 2'b00, 1, 1, 0);
    tick();
    check_idle("add_done");

    // mvnz R7,R1 with G == 0 then G != 0
    run = 1'b1; iin = 16'hBC80; g_zero = 1'b1;
    tick();
    run = 1'b0;
    check_out("mvnz_gzero", 0, 4'd0, 8'h00, 0, 0, 2'b00, 1, 1, 0);
    tick();
    run = 1'b1; g_zero = 1'b0;
    tick();
    run = 1'b0;
    check_out("mvnz_gnonzero", 0, 4'd1, 8'h80, 0, 0, 2'b00, 1, 1, 0);
    tick();

    // illegal opcode
    run = 1'b1; iin = 16'hE000;
    tick();
    run = 1'b0;
    check_out("illegal_t1", 0, 4'd0, 8'h00, 0, 0, 2'b00, 1, 1, 1);
    tick();
    check_idle("illegal_done");

    // sub R1,R2 with a stray run during T2
    run = 1'b1; iin = 16'h6500;
    tick();
    run = 1'b0;
    check_out("sub_t1", 0, 4'd1, 8'h00, 1, 0, 2'b00, 0, 1, 0);
    tick();
    run = 1'b1; iin = 16'h2C00;
    check_out("sub_t2_run_ignored", 0, 4'd2, 8'h00, 0, 1, 2'b01, 0, 1, 0);
    tick();
    run = 1'b0;
    check_out("sub_t3", 0, 4'd8, 8'h02, 0, 0, 2'b00, 1, 1, 0);
    tick();
    check_idle("sub_done");

    // and R2,R3
    run = 1'b1; iin = 16'h8980;
    tick();
    run = 1'b0;
    check_out("and_t1", 0, 4'd2, 8'h00, 1, 0, 2'b00, 0, 1, 0);
    tick();
    check_out("and_t2", 0, 4'd3, 8'h00, 0, 1, 2'b10, 0, 1, 0);
    tick();
    check_out("and_t3", 0, 4'd8, 8'h04, 0, 0, 2'b00, 1, 1, 0);
    tick();

    // mv R0,R5 with run held through done: next instruction starts in T0
    run = 1'b1; iin = 16'h0280;
    tick();
    iin = 16'h2C00;
    check_out("b2b_mv_t1", 0, 4'd5, 8'h01, 0, 0, 2'b00, 1, 1, 0);
    tick();
    check_out("b2b_t0", 1, 4'd0, 8'h00, 0, 0, 2'b00, 0, 0, 0);
    tick();
    run = 1'b0;
    check_out("b2b_mvi_t1", 0, 4'd9, 8'h08, 0, 0, 2'b00, 1, 1, 0);
    tick();

    // reset asserted during T2 of add
    run = 1'b1; iin = 16'h4500;
    tick();
    run = 1'b0;
    tick();
    check_out("rst_pre_t2", 0, 4'd2, 8'h00, 0, 1, 2'b00, 0, 1, 0);
    resetn = 1'b1; run = 1'b1;
    check_idle("rst_mid_add");
    tick();
    check_idle("rst_mid_add_held");
    resetn = 1'b0; iin = 16'h0280;
    check_out("post_rst_t0", 1, 4'd0, 8'h00, 0, 0, 2'b00, 0, 0, 0);
    tick();
    run = 1'b0;
    check_out("post_rst_mv_t1", 0, 4'd5, 8'h01, 0, 0, 2'b00, 1, 1, 0);
    tick();
    check_idle("post_rst_done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
